i281_multicycle_ctrl: RTL and testbench
=======================================

// Module: i281_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the i281 CPU; sits between the instruction decoder and the datapath.
//  Sequences IF/ID/Ex/Mem/Wb per 5-bit instruction class and drives PC, IR, register-file, ALU, flag and memory strobes.
//  Evaluates branch conditions from the flags and gates execution with the run input.
//  Exposes its state and a retired-instruction counter for bench monitoring.
// PARAMETERS
//  STATE_W  8   width of state output; encodings below must fit
//  CNT_W    16  width of retired-instruction counter
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high
//  run          in   1        1 = fetch new instructions; 0 = park in IF
//  instruction  in   5        decoded class: 0 NOOP,1 INPUTC,2 INPUTCF,3 INPUTD,4 GCD,5 MOVE,6 LOADIP,7 ADD,8 ADDI,9 SUB,10 SUBI,11 LOAD,12 LOADF,13 STORE,14 STOREF,15 SHIFTL,16 SHIFTR,17 CMP,18 JUMP,19 BRE/BRZ,20 BRNE/BRNZ,21 BRG,22 BRGE
//  flags        in   4        {C,O,N,Z} = [3:0] = {carry,overflow,negative,zero}
//  state        out  STATE_W  current state
//  pc_write     out  1        load PC
//  pc_sel       out  1        0 = PC+1, 1 = PC+offset (branch target)
//  ir_write     out  1        load IR from code memory
//  reg_write    out  1        register-file write enable
//  reg_wsel     out  2        write source: 0 ALU, 1 data mem, 2 immediate, 3 other register
//  alu_op       out  2        0 add, 1 sub, 2 shl, 3 shr
//  alu_src_imm  out  1        ALU B operand = immediate
//  flags_write  out  1        load flag register
//  mem_read     out  1        data memory read strobe
//  mem_write    out  1        data memory write strobe
//  code_write   out  1        code memory write (INPUTC/INPUTCF)
//  illegal      out  1        1-cycle pulse in ID for codes 4 and 23..31
//  instr_done   out  1        1-cycle pulse on final state of each instruction
//  retired      out  CNT_W    count of instr_done pulses, wraps at 2^CNT_W
// BEHAVIOUR
//  Encodings: IF=0 ID=1 ExALU=2 ExALUI=3 ExJUMP=4 ExBRANCH=5 MemREAD=6 MemWRITE=7 WbALU=8 WbLOAD=9 ExLOAD=10 ExIMM=11.
//  Reset (async): state=IF, retired=0; all strobes are 0 while reset is high; it aborts any in-flight instruction.
//  All strobes are Moore outputs of state + latched instruction; no strobe in a state not listed below.
//  IF: if run=1 -> pc_write=1, pc_sel=0, ir_write=1, next ID; if run=0 -> all strobes 0, stay IF.
//  ID: no datapath writes; instruction sampled this cycle and held until return to IF.
//   NOOP / illegal -> instr_done, next IF; MOVE/LOADIP/INPUT* -> ExIMM; ADD/SUB/SHIFT*/CMP -> ExALU;
//   ADDI/SUBI -> ExALUI; LOAD*/STORE* -> ExLOAD; JUMP -> ExJUMP; BR* -> ExBRANCH.
//  ExIMM: MOVE reg_write, wsel=3; LOADIP reg_write, wsel=2; INPUTD reg_write, wsel=2; INPUTC/CF code_write; instr_done; next IF.
//  ExALU/ExALUI: alu_op from class, alu_src_imm = (ExALUI), flags_write=1; CMP -> alu_op=sub, instr_done, next IF; else next WbALU.
//  WbALU: reg_write=1, wsel=0, instr_done, next IF.
//  ExLOAD: address add (alu_op=add, alu_src_imm=1); LOAD* -> MemREAD, STORE* -> MemWRITE.
//  MemREAD: mem_read=1, next WbLOAD. WbLOAD: reg_write=1, wsel=1, instr_done, next IF.
//  MemWRITE: mem_write=1, instr_done, next IF.
//  ExJUMP: pc_write=1, pc_sel=1, instr_done, next IF.
//  ExBRANCH: taken = BRE: Z; BRNE: !Z; BRG: !Z & (N==O); BRGE: N==O; taken -> pc_write=1, pc_sel=1; instr_done; next IF.
//  Latency (cycles IF..last, inclusive): NOOP 2; ExIMM class 3; branch/jump 3; CMP 3; ALU 4; STORE 4; LOAD 5.
//  run falling mid-instruction: instruction completes; FSM then parks in IF. run rising: fetch on the next IF cycle.
//  flags sampled only in ExBRANCH; flags_write and a branch never coincide.
// STRUCTURE
//  i281_ctrl_pkg: state encodings, instruction class codes, alu_op and reg_wsel codes, flag bit indices.
//  Sub-module i281_branch_eval: combinational (class, flags) -> taken; instantiated once.
// TESTING
//  reset=1 for 2 cycles mid-LOAD (state=MemREAD) -> state=0, all strobes 0 immediately, retired=0.
//  run=0, 10 cycles -> state stays 0, pc_write=ir_write=0, retired unchanged.
//  run=1, instruction=11 (LOAD) -> states 0,1,10,6,9; mem_read only in 6; reg_write with wsel=1 only in 9; retired +1.
//  instruction=17 (CMP) -> states 0,1,2; flags_write=1, alu_op=1 in 2; no reg_write; back to 0.
//  instruction=21 (BRG): flags=4'b0000 -> pc_write and pc_sel=1 in 5; flags=4'b0010 (N=1,O=0) -> no pc_write in 5.
//  instruction=23 -> illegal pulse in ID, instr_done, state=0 after 2 cycles; retired wraps 0xFFFF->0x0000.

Source files
------------

// File: rtl/i281_ctrl_pkg.sv
// Shared encodings for the i281 multicycle controller: states, instruction
// classes, ALU/write-select codes, flag bit positions and the strobe bundle.
package i281_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EXALU    = 4'd2,
        S_EXALUI   = 4'd3,
        S_EXJUMP   = 4'd4,
        S_EXBRANCH = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWRITE = 4'd7,
        S_WBALU    = 4'd8,
        S_WBLOAD   = 4'd9,
        S_EXLOAD   = 4'd10,
        S_EXIMM    = 4'd11
    } state_t;

    localparam logic [4:0] I_NOOP    = 5'd0;
    localparam logic [4:0] I_INPUTC  = 5'd1;
    localparam logic [4:0] I_INPUTCF = 5'd2;
    localparam logic [4:0] I_INPUTD  = 5'd3;
    localparam logic [4:0] I_GCD     = 5'd4;
    localparam logic [4:0] I_MOVE    = 5'd5;
    localparam logic [4:0] I_LOADIP  = 5'd6;
    localparam logic [4:0] I_ADD     = 5'd7;
    localparam logic [4:0] I_ADDI    = 5'd8;
    localparam logic [4:0] I_SUB     = 5'd9;
    localparam logic [4:0] I_SUBI    = 5'd10;
    localparam logic [4:0] I_LOAD    = 5'd11;
    localparam logic [4:0] I_LOADF   = 5'd12;
    localparam logic [4:0] I_STORE   = 5'd13;
    localparam logic [4:0] I_STOREF  = 5'd14;
    localparam logic [4:0] I_SHIFTL  = 5'd15;
    localparam logic [4:0] I_SHIFTR  = 5'd16;
    localparam logic [4:0] I_CMP     = 5'd17;
    localparam logic [4:0] I_JUMP    = 5'd18;
    localparam logic [4:0] I_BRE     = 5'd19;
    localparam logic [4:0] I_BRNE    = 5'd20;
    localparam logic [4:0] I_BRG     = 5'd21;
    localparam logic [4:0] I_BRGE    = 5'd22;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SHL = 2'd2;
    localparam logic [1:0] ALU_SHR = 2'd3;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_IMM = 2'd2;
    localparam logic [1:0] WSEL_REG = 2'd3;

    localparam int F_C = 3;
    localparam int F_O = 2;
    localparam int F_N = 1;
    localparam int F_Z = 0;

    typedef struct packed {
        logic       pc_write;
        logic       pc_sel;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_wsel;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       flags_write;
        logic       mem_read;
        logic       mem_write;
        logic       code_write;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_illegal(input logic [4:0] i);
        return (i == I_GCD) || (i > I_BRGE);
    endfunction

    // Dispatch from ID; NOOP and illegal codes retire without an Ex state.
    function automatic state_t id_route(input logic [4:0] i);
        state_t r;
        r = S_IF;
        unique case (1'b1)
            is_illegal(i),
            i == I_NOOP:
                r = S_IF;
            i inside {I_INPUTC, I_INPUTCF, I_INPUTD, I_MOVE, I_LOADIP}:
                r = S_EXIMM;
            i inside {I_ADD, I_SUB, I_SHIFTL, I_SHIFTR, I_CMP}:
                r = S_EXALU;
            i inside {I_ADDI, I_SUBI}:
                r = S_EXALUI;
            i inside {I_LOAD, I_LOADF, I_STORE, I_STOREF}:
                r = S_EXLOAD;
            i == I_JUMP:
                r = S_EXJUMP;
            default:
                r = S_EXBRANCH;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] alu_op_of(input logic [4:0] i);
        logic [1:0] r;
        r = ALU_ADD;
        unique case (1'b1)
            i inside {I_SUB, I_SUBI, I_CMP}: r = ALU_SUB;
            i == I_SHIFTL:                   r = ALU_SHL;
            i == I_SHIFTR:                   r = ALU_SHR;
            default:                         r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i281_branch_eval.sv
// Branch condition evaluation for the i281 branch classes.
// Combinational: non-branch classes never report taken.
module i281_branch_eval
    import i281_ctrl_pkg::*;
(
    input  logic [4:0] instr,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z;
    logic n_eq_o;

    assign z      = flags[F_Z];
    assign n_eq_o = (flags[F_N] == flags[F_O]);

    always_comb begin
        taken = 1'b0;
        unique case (instr)
            I_BRE:   taken = z;
            I_BRNE:  taken = !z;
            I_BRG:   taken = !z && n_eq_o;
            I_BRGE:  taken = n_eq_o;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/i281_multicycle_ctrl.sv
// Multicycle control FSM for the i281 CPU: sequences IF/ID/Ex/Mem/Wb per
// instruction class and drives the datapath strobes as Moore outputs.
module i281_multicycle_ctrl
    import i281_ctrl_pkg::*;
#(
    parameter int STATE_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [4:0]         instruction,
    input  logic [3:0]         flags,
    output logic [STATE_W-1:0] state,
    output logic               pc_write,
    output logic               pc_sel,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_wsel,
    output logic [1:0]         alu_op,
    output logic               alu_src_imm,
    output logic               flags_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               code_write,
    output logic               illegal,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired
);

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       instr_q;
    logic [CNT_W-1:0] retired_q;
    logic             taken;
    ctrl_t            ctrl;
    ctrl_t            ctrl_o;

    i281_branch_eval u_branch_eval (
        .instr (instr_q),
        .flags (flags),
        .taken (taken)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            instr_q <= I_NOOP;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID)
                instr_q <= instruction;
        end
    end

    always_comb begin
        state_d = S_IF;
        unique case (state_q)
            S_IF:      state_d = run ? S_ID : S_IF;
            S_ID:      state_d = id_route(instruction);
            S_EXALU,
            S_EXALUI:  state_d = (instr_q == I_CMP) ? S_IF : S_WBALU;
            S_EXLOAD:  state_d = (instr_q inside {I_LOAD, I_LOADF})
                                 ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_WBLOAD;
            default:   state_d = S_IF;
        endcase
    end

    // ID decodes the live instruction; later states use the latched copy.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_IF: begin
                ctrl.pc_write = run;
                ctrl.ir_write = run;
            end
            S_ID: begin
                ctrl.illegal    = is_illegal(instruction);
                ctrl.instr_done = is_illegal(instruction)
                                  || (instruction == I_NOOP);
            end
            S_EXIMM: begin
                ctrl.instr_done = 1'b1;
                unique case (instr_q)
                    I_MOVE: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_wsel  = WSEL_REG;
                    end
                    I_LOADIP,
                    I_INPUTD: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_wsel  = WSEL_IMM;
                    end
                    I_INPUTC,
                    I_INPUTCF: ctrl.code_write = 1'b1;
                    default: ;
                endcase
            end
            S_EXALU,
            S_EXALUI: begin
                ctrl.alu_op      = alu_op_of(instr_q);
                ctrl.alu_src_imm = (state_q == S_EXALUI);
                ctrl.flags_write = 1'b1;
                ctrl.instr_done  = (instr_q == I_CMP);
            end
            S_WBALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_wsel   = WSEL_ALU;
                ctrl.instr_done = 1'b1;
            end
            S_EXLOAD: begin
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu_src_imm = 1'b1;
            end
            S_MEMREAD:
                ctrl.mem_read = 1'b1;
            S_WBLOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_wsel   = WSEL_MEM;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXJUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_sel     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXBRANCH: begin
                ctrl.pc_write   = taken;
                ctrl.pc_sel     = taken;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Strobes are forced low for the whole reset assertion, not just after.
    assign ctrl_o = reset ? '0 : ctrl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            retired_q <= '0;
        else if (ctrl_o.instr_done)
            retired_q <= retired_q + CNT_W'(1);
    end

    assign state       = STATE_W'(state_q);
    assign pc_write    = ctrl_o.pc_write;
    assign pc_sel      = ctrl_o.pc_sel;
    assign ir_write    = ctrl_o.ir_write;
    assign reg_write   = ctrl_o.reg_write;
    assign reg_wsel    = ctrl_o.reg_wsel;
    assign alu_op      = ctrl_o.alu_op;
    assign alu_src_imm = ctrl_o.alu_src_imm;
    assign flags_write = ctrl_o.flags_write;
    assign mem_read    = ctrl_o.mem_read;
    assign mem_write   = ctrl_o.mem_write;
    assign code_write  = ctrl_o.code_write;
    assign illegal     = ctrl_o.illegal;
    assign instr_done  = ctrl_o.instr_done;
    assign retired     = retired_q;

endmodule

// File: tb/tb_i281_multicycle_ctrl.sv
// Directed bench for i281_multicycle_ctrl; a narrow retired counter
// keeps the wrap-around scenario short.
module tb_i281_multicycle_ctrl;

    localparam int CNT_W = 8;

    logic             clock;
    logic             reset;
    logic             run;
    logic [4:0]       instruction;
    logic [3:0]       flags;
    logic [7:0]       state;
    logic             pc_write, pc_sel, ir_write, reg_write;
    logic [1:0]       reg_wsel, alu_op;
    logic             alu_src_imm, flags_write, mem_read, mem_write;
    logic             code_write, illegal, instr_done;
    logic [CNT_W-1:0] retired;
    logic             any_strobe;

    int checks = 0;
    int fails  = 0;

    i281_multicycle_ctrl #(.STATE_W(8), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .flags       (flags),
        .state       (state),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_wsel    (reg_wsel),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .flags_write (flags_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .code_write  (code_write),
        .illegal     (illegal),
        .instr_done  (instr_done),
        .retired     (retired)
    );

    assign any_strobe = pc_write | pc_sel | ir_write | reg_write
                      | (reg_wsel != 2'd0) | (alu_op != 2'd0)
                      | alu_src_imm | flags_write | mem_read | mem_write
                      | code_write | illegal | instr_done;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; instruction = 5'd0; flags = 4'd0;
        step(); step();
        checks++;
        if (state !== 8'd0) begin
            fails++; $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if (any_strobe !== 1'b0) begin
            fails++; $display("FAIL reset_strobes got %b want 0", any_strobe);
        end
        checks++;
        if (retired !== 8'd0) begin
            fails++; $display("FAIL reset_retired got %0d want 0", retired);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        logic [CNT_W-1:0] r0;
        r0 = retired;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (state !== 8'd0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
                fails++;
                $display("FAIL idle cyc%0d state=%0d pcw=%b irw=%b want 0,0,0",
                         i, state, pc_write, ir_write);
            end
        end
        checks++;
        if (retired !== r0) begin
            fails++; $display("FAIL idle_retired got %0d want %0d", retired, r0);
        end
    endtask

    task automatic test_load();
        logic [7:0] exp_st [4] = '{8'd1, 8'd10, 8'd6, 8'd9};
        logic [CNT_W-1:0] r0;
        r0 = retired;
        run = 1'b1; instruction = 5'd11;
        #1;
        checks++;
        if (state !== 8'd0 || pc_write !== 1'b1 || pc_sel !== 1'b0
            || ir_write !== 1'b1) begin
            fails++;
            $display("FAIL load_if state=%0d pcw=%b pcs=%b irw=%b want 0,1,0,1",
                     state, pc_write, pc_sel, ir_write);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== exp_st[i]
                || mem_read !== (exp_st[i] == 8'd6)
                || (reg_write && reg_wsel == 2'd1) !== (exp_st[i] == 8'd9)) begin
                fails++;
                $display("FAIL load_seq%0d state=%0d mrd=%b rw=%b ws=%0d want st %0d",
                         i, state, mem_read, reg_write, reg_wsel, exp_st[i]);
            end
        end
        checks++;
        if (alu_src_imm !== 1'b0) begin
            fails++; $display("FAIL load_wb_imm got %b want 0", alu_src_imm);
        end
        step();
        checks++;
        if (state !== 8'd0 || retired !== r0 + 8'd1) begin
            fails++;
            $display("FAIL load_end state=%0d ret=%0d want 0,%0d",
                     state, retired, r0 + 8'd1);
        end
    endtask

    task automatic test_cmp();
        logic [CNT_W-1:0] r0;
        r0 = retired;
        instruction = 5'd17;
        step();
        step();
        checks++;
        if (state !== 8'd2 || flags_write !== 1'b1 || alu_op !== 2'd1
            || reg_write !== 1'b0 || instr_done !== 1'b1) begin
            fails++;
            $display("FAIL cmp_ex state=%0d fw=%b op=%0d rw=%b done=%b want 2,1,1,0,1",
                     state, flags_write, alu_op, reg_write, instr_done);
        end
        step();
        checks++;
        if (state !== 8'd0 || reg_write !== 1'b0 || retired !== r0 + 8'd1) begin
            fails++;
            $display("FAIL cmp_end state=%0d rw=%b ret=%0d want 0,0,%0d",
                     state, reg_write, retired, r0 + 8'd1);
        end
    endtask

    task automatic test_branch();
        logic [3:0] fl    [2] = '{4'b0000, 4'b0010};
        logic       exp_t [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            instruction = 5'd21; flags = fl[k];
            step();
            step();
            checks++;
            if (state !== 8'd5 || pc_write !== exp_t[k] || pc_sel !== exp_t[k]
                || flags_write !== 1'b0 || instr_done !== 1'b1) begin
                fails++;
                $display("FAIL brg%0d state=%0d pcw=%b pcs=%b fw=%b want 5,%b,%b,0",
                         k, state, pc_write, pc_sel, flags_write, exp_t[k], exp_t[k]);
            end
            step();
        end
        flags = 4'd0;
    endtask

    // Cycles from IF through the instr_done state, inclusive.
    task automatic test_latency();
        logic [4:0] ins [9] = '{5'd0, 5'd5, 5'd6, 5'd13, 5'd18,
                                5'd7, 5'd10, 5'd19, 5'd12};
        int         lat [9] = '{2, 3, 3, 4, 3, 4, 4, 3, 5};
        int         n;
        run = 1'b1; flags = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            instruction = ins[k];
            n = 1;
            while (instr_done !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            checks++;
            if (n !== lat[k]) begin
                fails++;
                $display("FAIL latency ins%0d got %0d want %0d", ins[k], n, lat[k]);
            end
            step();
        end
        flags = 4'd0;
    endtask

    task automatic test_exec_strobes();
        instruction = 5'd8;
        step(); step();
        checks++;
        if (state !== 8'd3 || alu_src_imm !== 1'b1 || alu_op !== 2'd0
            || flags_write !== 1'b1) begin
            fails++;
            $display("FAIL addi_ex state=%0d imm=%b op=%0d fw=%b want 3,1,0,1",
                     state, alu_src_imm, alu_op, flags_write);
        end
        step();
        checks++;
        if (state !== 8'd8 || reg_write !== 1'b1 || reg_wsel !== 2'd0) begin
            fails++;
            $display("FAIL addi_wb state=%0d rw=%b ws=%0d want 8,1,0",
                     state, reg_write, reg_wsel);
        end
        step();
        instruction = 5'd2;
        step(); step();
        checks++;
        if (state !== 8'd11 || code_write !== 1'b1 || reg_write !== 1'b0) begin
            fails++;
            $display("FAIL inputcf state=%0d cw=%b rw=%b want 11,1,0",
                     state, code_write, reg_write);
        end
        step();
        instruction = 5'd16;
        step(); step();
        checks++;
        if (state !== 8'd2 || alu_op !== 2'd3) begin
            fails++;
            $display("FAIL shiftr state=%0d op=%0d want 2,3", state, alu_op);
        end
        step(); step();
    endtask

    task automatic test_run_drop();
        instruction = 5'd7;
        step();
        run = 1'b0;
        step();
        checks++;
        if (state !== 8'd2) begin
            fails++; $display("FAIL rundrop_ex got %0d want 2", state);
        end
        step();
        checks++;
        if (state !== 8'd8 || reg_write !== 1'b1) begin
            fails++;
            $display("FAIL rundrop_wb state=%0d rw=%b want 8,1", state, reg_write);
        end
        step(); step(); step();
        checks++;
        if (state !== 8'd0 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL rundrop_park state=%0d pcw=%b want 0,0", state, pc_write);
        end
        run = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            fails++; $display("FAIL run_rise pcw got %b want 1", pc_write);
        end
    endtask

    task automatic test_reset_mid_load();
        instruction = 5'd11; run = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 8'd6) begin
            fails++; $display("FAIL midload_pre got %0d want 6", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 8'd0 || any_strobe !== 1'b0 || retired !== 8'd0) begin
            fails++;
            $display("FAIL midload_rst state=%0d strobes=%b ret=%0d want 0,0,0",
                     state, any_strobe, retired);
        end
        step(); step();
        checks++;
        if (state !== 8'd0 || any_strobe !== 1'b0) begin
            fails++;
            $display("FAIL midload_hold state=%0d strobes=%b want 0,0",
                     state, any_strobe);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_illegal_wrap();
        instruction = 5'd23;
        step();
        checks++;
        if (state !== 8'd1 || illegal !== 1'b1 || instr_done !== 1'b1) begin
            fails++;
            $display("FAIL illegal_id state=%0d ill=%b done=%b want 1,1,1",
                     state, illegal, instr_done);
        end
        step();
        checks++;
        if (state !== 8'd0 || illegal !== 1'b0 || retired !== 8'd1) begin
            fails++;
            $display("FAIL illegal_end state=%0d ill=%b ret=%0d want 0,0,1",
                     state, illegal, retired);
        end
        instruction = 5'd4;
        step();
        checks++;
        if (illegal !== 1'b1) begin
            fails++; $display("FAIL gcd_illegal got %b want 1", illegal);
        end
        step();
        instruction = 5'd31;
        for (int i = 0; i < 253; i++) begin
            step(); step();
        end
        checks++;
        if (retired !== 8'hFF) begin
            fails++; $display("FAIL wrap_pre got %0h want ff", retired);
        end
        step(); step();
        checks++;
        if (retired !== 8'h00) begin
            fails++; $display("FAIL wrap got %0h want 0", retired);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_cmp();
        test_branch();
        test_latency();
        test_exec_strobes();
        test_run_drop();
        test_reset_mid_load();
        test_illegal_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
